march_sequencer: RTL and testbench
==================================

MARCH_SEQUENCER -- requirements
Module: march_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width; memory depth N = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, data width, matching the comparator's data_t/ramout width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a March C- run.
REQ-006 SHALL have port eq  input  1  comparator equality result (ramout == data_t).
REQ-007 SHALL have port addr  output  ADDR_W  memory address under test.
REQ-008 SHALL have port data_t  output  DATA_W  write data and expected read data, also driven to the comparator.
REQ-009 SHALL have port we  output  1  memory write enable.
REQ-010 SHALL have port re  output  1  memory read enable; memory returns ramout one cycle later.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-013 SHALL have port fail  output  1  sticky mismatch flag for the current/last run.
REQ-014 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch.
REQ-015 SHALL have port fail_elem  output  3  March element index (0-5) of the first mismatch.

Function
REQ-016 SHALL execute March C- elements in order: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-017 SHALL use background 0 = all-zeros and 1 = all-ones on data_t.
REQ-018 SHALL use FSM states IDLE, WRITE, READ, CHECK, DONE.
REQ-019 SHALL accept start only in IDLE; IDLE->WRITE for E0, addr=0; start in any other state ignored.
REQ-020 SHALL, in WRITE, drive we=1, re=0, with data_t = element write value for one cycle.
REQ-021 SHALL, in READ, drive re=1, we=0, with data_t = expected value for one cycle, then go to CHECK.
REQ-022 SHALL, in CHECK, drive re=0, we=0, hold addr/data_t, and sample eq on the closing edge.
REQ-023 SHALL, after CHECK, go to WRITE for E1-E4 (same addr); for E5, advance addr.
REQ-024 SHALL advance addr +1 in up elements (0..N-1) and -1 in down elements (N-1..0); the element change and address reload (0 or N-1) occur in the same cycle as the element's last op, with no idle cycles.
REQ-025 SHALL take exactly 15N busy cycles per run (E0: N; E1-E4: 3N each; E5: 2N).
REQ-026 SHALL go to DONE after the last E5 CHECK; DONE asserts done=1, busy=0 for one cycle, then returns to IDLE.
REQ-027 SHALL, on the first CHECK with eq=0 in a run, set fail=1 and capture fail_addr and fail_elem; later mismatches SHALL NOT alter them; the run SHALL continue to completion.
REQ-028 SHALL clear fail, fail_addr, and fail_elem when start is accepted; otherwise hold them through IDLE.
REQ-029 SHALL drive busy=1 in WRITE/READ/CHECK only.
REQ-030 SHALL ignore eq outside CHECK.
REQ-031 SHALL wrap addr arithmetic modulo 2^ADDR_W; no out-of-range address SHALL ever be driven.

Reset
REQ-032 SHALL, on rst_n=0 (any state, including mid-run), immediately set: state=IDLE, addr=0, data_t=0, we=0, re=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0.
REQ-033 SHALL, after rst_n deassertion, stay in IDLE until start is sampled high.

Verification
REQ-034 SHALL verify: start with fault-free RAM model, ADDR_W=5 -> busy high exactly 480 cycles, done pulse one cycle, fail=0.
REQ-035 SHALL verify: first 34 cycles after start -> addr 0..31 with we=1, data_t=8'h00; then re=1 at addr 0 with data_t=8'h00; then CHECK; then we=1 at addr 0 with data_t=8'hFF.
REQ-036 SHALL verify: RAM bit 0 stuck-at-1 at addr 5 -> fail=1, fail_addr=5, fail_elem=1; values unchanged at done despite later mismatches.
REQ-037 SHALL verify: start pulsed at cycle 100 of a run -> ignored; run length still 480 cycles.
REQ-038 SHALL verify: rst_n low during E3 -> all outputs 0 immediately; a new start then gives a full 480-cycle run.
REQ-039 SHALL verify: failing run followed by a start with a fault-free RAM -> fail clears on start acceptance; done with fail=0.

Source files
------------

// File: rtl/march_sequencer.sv
// rtl/march_sequencer.sv - March C- memory test sequencer with first-failure capture
module march_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              eq,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_t,
  output logic              we,
  output logic              re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // March C- has six elements, E0..E5; E5 is read-only and ends the run
  localparam logic [2:0] ELEM_FIRST = 3'd0;
  localparam logic [2:0] ELEM_LAST  = 3'd5;

  localparam logic [DATA_W-1:0] BG_ZERO = '0;
  localparam logic [DATA_W-1:0] BG_ONE  = '1;
  localparam logic [ADDR_W-1:0] ADDR_LO = '0;
  localparam logic [ADDR_W-1:0] ADDR_HI = '1;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [2:0]        elem;
  logic [2:0]        elem_nxt;
  logic [2:0]        elem_inc;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_step;
  logic [DATA_W-1:0] data_nxt;
  logic              last_addr;
  logic              accept;
  logic              mismatch;

  // E3 and E4 walk the array from the top address down
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Write background: E1 and E3 write ones, E0/E2/E4 write zeros
  function automatic logic [DATA_W-1:0] write_val(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? BG_ONE : BG_ZERO;
  endfunction

  // Expected read background: E2 and E4 read ones, E1/E3/E5 read zeros
  function automatic logic [DATA_W-1:0] read_val(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? BG_ONE : BG_ZERO;
  endfunction

  // First address visited by an element
  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
    return elem_down(e) ? ADDR_HI : ADDR_LO;
  endfunction

  // Final address visited by an element
  function automatic logic [ADDR_W-1:0] final_addr(input logic [2:0] e);
    return elem_down(e) ? ADDR_LO : ADDR_HI;
  endfunction

  // Address stepping and end-of-element detection; wraps naturally modulo 2^ADDR_W
  always_comb begin
    addr_step = elem_down(elem) ? (addr - 1'b1) : (addr + 1'b1);
    last_addr = (addr == final_addr(elem));
    elem_inc  = elem + 3'd1;
    accept    = (state == ST_IDLE) && start;
    mismatch  = (state == ST_CHECK) && !eq;
  end

  // Next-state logic: the element change and address reload happen on the
  // element's final operation so no idle cycle separates two elements
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    data_nxt  = data_t;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WRITE;
          elem_nxt  = ELEM_FIRST;
          addr_nxt  = ADDR_LO;
          data_nxt  = write_val(ELEM_FIRST);
        end
      end
      ST_WRITE: begin
        if (last_addr) begin
          // Closing write of E0..E4: move straight into the next element's first read
          state_nxt = ST_READ;
          elem_nxt  = elem_inc;
          addr_nxt  = first_addr(elem_inc);
          data_nxt  = read_val(elem_inc);
        end else if (elem == ELEM_FIRST) begin
          // E0 is a pure write sweep, one address per cycle
          addr_nxt = addr_step;
        end else begin
          state_nxt = ST_READ;
          addr_nxt  = addr_step;
          data_nxt  = read_val(elem);
        end
      end
      ST_READ: begin
        // Memory answers one cycle after re, so the compare happens in CHECK
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (elem == ELEM_LAST) begin
          if (last_addr) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_READ;
            addr_nxt  = addr_step;
            data_nxt  = read_val(elem);
          end
        end else begin
          // Read-then-write elements write back at the same address
          state_nxt = ST_WRITE;
          data_nxt  = write_val(elem);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, element, address and background registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      elem   <= ELEM_FIRST;
      addr   <= ADDR_LO;
      data_t <= BG_ZERO;
    end else begin
      state  <= state_nxt;
      elem   <= elem_nxt;
      addr   <= addr_nxt;
      data_t <= data_nxt;
    end
  end

  // First-mismatch capture; cleared when a new run is accepted, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else if (accept) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else if (mismatch && !fail) begin
      fail      <= 1'b1;
      fail_addr <= addr;
      fail_elem <= elem;
    end
  end

  // Memory strobes and status decode directly from state, so reset clears them at once
  always_comb begin
    we   = (state == ST_WRITE);
    re   = (state == ST_READ);
    busy = (state == ST_WRITE) || (state == ST_READ) || (state == ST_CHECK);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_march_sequencer.sv
// tb/tb_march_sequencer.sv - self-checking bench for march_sequencer with faulty RAM model
module tb_march_sequencer;

  localparam int AW      = 5;
  localparam int DW      = 8;
  localparam int N       = 1 << AW;
  localparam int RUN_LEN = 15 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          eq;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_t;
  logic          we;
  logic          re;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .eq        (eq),
    .addr      (addr),
    .data_t    (data_t),
    .we        (we),
    .re        (re),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  // RAM with an optional single stuck-at bit seen on reads
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ramout = '0;
  bit            fault_en  = 1'b0;
  int            fault_adr = 0;
  int            fault_bit = 0;
  bit            fault_val = 1'b0;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (fault_en && a == fault_adr) r[fault_bit] = fault_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (we) mem[addr] <= data_t;
    if (re) ramout <= faulty(int'(addr), mem[addr]);
  end

  assign eq = (ramout == data_t);

  // Expected per-cycle bus activity, built from the March C- element list
  typedef struct {
    bit            w;
    bit            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  op_t exp_q[$];

  function automatic bit is_down(input int e);
    return (e == 3) || (e == 4);
  endfunction

  function automatic logic [DW-1:0] rd_bg(input int e);
    return (e == 2 || e == 4) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [DW-1:0] wr_bg(input int e);
    return (e == 1 || e == 3) ? 8'hFF : 8'h00;
  endfunction

  task automatic build_expected();
    op_t o;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        o.a = AW'(is_down(e) ? N - 1 - i : i);
        if (e == 0) begin
          o.w = 1; o.r = 0; o.d = 8'h00; exp_q.push_back(o);
        end else begin
          o.w = 0; o.r = 1; o.d = rd_bg(e); exp_q.push_back(o);
          o.w = 0; o.r = 0;                 exp_q.push_back(o);
          if (e < 5) begin
            o.w = 1; o.r = 0; o.d = wr_bg(e); exp_q.push_back(o);
          end
        end
      end
    end
  endtask

  // Replays the test on an array memory to find the first failing read
  task automatic model_fail(output bit f, output logic [AW-1:0] fa, output logic [2:0] fe);
    logic [DW-1:0] m [N];
    int a;
    f = 0; fa = '0; fe = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = is_down(e) ? N - 1 - i : i;
        if (e == 0) begin
          m[a] = 8'h00;
        end else begin
          if (!f && faulty(a, m[a]) !== rd_bg(e)) begin
            f = 1; fa = AW'(a); fe = 3'(e);
          end
          if (e < 5) m[a] = wr_bg(e);
        end
      end
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // One full run: trace, done pulse and failure report against the model
  task automatic do_run(input string name, input int poke);
    int            terr;
    string         first;
    bit            xf;
    logic [AW-1:0] xfa;
    logic [2:0]    xfe;
    build_expected();
    model_fail(xf, xfa, xfe);
    terr  = 0;
    first = "";
    start_pulse();
    total++;
    if ({fail, fail_addr, fail_elem} !== '0) begin
      $display("FAIL %s clear_on_start: fail=%0b addr=%0d elem=%0d, required all 0", name, fail, fail_addr, fail_elem);
    end else passed++;
    for (int k = 0; k < RUN_LEN; k++) begin
      start = (k == poke);
      if (busy !== 1'b1 || done !== 1'b0 || we !== exp_q[k].w || re !== exp_q[k].r ||
          addr !== exp_q[k].a || data_t !== exp_q[k].d) begin
        if (terr == 0)
          first = $sformatf("cycle %0d got busy=%0b done=%0b we=%0b re=%0b addr=%0d data=%02h need we=%0b re=%0b addr=%0d data=%02h",
                            k, busy, done, we, re, addr, data_t, exp_q[k].w, exp_q[k].r, exp_q[k].a, exp_q[k].d);
        terr++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (terr != 0) $display("FAIL %s trace: %0d bad cycles, first %s", name, terr, first);
    else passed++;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0 || re !== 1'b0) begin
      $display("FAIL %s done_pulse: done=%0b busy=%0b we=%0b re=%0b, required 1 0 0 0", name, done, busy, we, re);
    end else passed++;
    total++;
    if (fail !== xf) $display("FAIL %s fail_flag: got %0b required %0b", name, fail, xf);
    else passed++;
    if (xf) begin
      total++;
      if (fail_addr !== xfa || fail_elem !== xfe)
        $display("FAIL %s fail_info: got addr=%0d elem=%0d required addr=%0d elem=%0d", name, fail_addr, fail_elem, xfa, xfe);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s after_done: done=%0b busy=%0b, required 0 0", name, done, busy);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({addr, data_t, we, re, busy, done, fail, fail_addr, fail_elem} !== '0)
      $display("FAIL %s outputs: addr=%0d data=%02h we=%0b re=%0b busy=%0b done=%0b fail=%0b fa=%0d fe=%0d, required all 0",
               name, addr, data_t, we, re, busy, done, fail, fail_addr, fail_elem);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b0 || we !== 1'b0 || re !== 1'b0) $display("FAIL idle_hold: busy=%0b we=%0b re=%0b, required 0", busy, we, re);
    else passed++;
  endtask

  task automatic test_fault_free();
    fault_en = 1'b0;
    do_run("fault_free", -1);
  endtask

  task automatic test_stuck_addr5();
    fault_en = 1'b1; fault_adr = 5; fault_bit = 0; fault_val = 1'b1;
    do_run("stuck_addr5", -1);
    total++;
    if (fail !== 1'b1 || fail_addr !== 5'd5 || fail_elem !== 3'd1)
      $display("FAIL stuck_addr5_held: fail=%0b addr=%0d elem=%0d required 1 5 1", fail, fail_addr, fail_elem);
    else passed++;
  endtask

  task automatic test_fail_clears();
    repeat (5) @(negedge clk);
    total++;
    if (fail !== 1'b1) $display("FAIL fail_held_idle: got %0b required 1", fail);
    else passed++;
    fault_en = 1'b0;
    do_run("fail_clears", -1);
  endtask

  task automatic test_start_ignored();
    fault_en = 1'b0;
    do_run("start_ignored", 100);
  endtask

  task automatic test_reset_mid_run();
    fault_en = 1'b1; fault_adr = 0; fault_bit = 3; fault_val = 1'b1;
    start_pulse();
    repeat (250) @(negedge clk);
    total++;
    if (busy !== 1'b1 || fail !== 1'b1) $display("FAIL mid_run_state: busy=%0b fail=%0b required 1 1", busy, fail);
    else passed++;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_run_reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("post_reset_idle");
    fault_en = 1'b0;
    do_run("after_reset", -1);
  endtask

  task automatic test_random_faults();
    for (int t = 0; t < 4; t++) begin
      fault_en  = ($urandom_range(0, 3) != 0);
      fault_adr = $urandom_range(0, N - 1);
      fault_bit = $urandom_range(0, DW - 1);
      fault_val = 1'($urandom_range(0, 1));
      do_run($sformatf("random%0d", t), $urandom_range(0, RUN_LEN - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_fault_free();
    test_stuck_addr5();
    test_fail_clears();
    test_start_ignored();
    test_reset_mid_run();
    test_random_faults();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
